// File: rtl/io_axil_bridge_pkg.sv
// io_axil_bridge_pkg
//   Shared definitions for the IO-bus to AXI4-Lite bridge: FSM state
//   encoding, AXI response codes, default read-timeout data and a
//   saturating counter helper.
package io_axil_bridge_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR      = 3'd1;  // AW and/or W still pending
    localparam logic [2:0] ST_WR_RESP = 3'd2;
    localparam logic [2:0] ST_RD_ADDR = 3'd3;
    localparam logic [2:0] ST_RD_DATA = 3'd4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

    // 8-bit add that sticks at 8'hFF instead of wrapping
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {7'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/axil_timeout_ctr.sv
// axil_timeout_ctr
//   Counts cycles of an outstanding transaction and flags expiry.
//   Ports:
//     clk, rst   clock, asynchronous active-high reset
//     i_clr      transaction issued this cycle (restarts the count)
//     i_en       transaction outstanding
//     o_expired  forced completion must happen on this edge
//   TIMEOUT = 0 never expires.
module axil_timeout_ctr #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] r_cnt;

    // The issue cycle itself counts as one, so expiry on the edge closing
    // cycle TIMEOUT-1 puts the forced completion exactly TIMEOUT cycles
    // after the request was accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= CW'(1);
        else if (i_en && (r_cnt != '1))
            r_cnt <= r_cnt + CW'(1);
    end

    assign o_expired = (TIMEOUT != 0) && i_en && (r_cnt >= CW'(TIMEOUT - 1));

endmodule

// File: rtl/io_axil_bridge.sv
// io_axil_bridge
//   Converts the CPU single-strobe IO bus into AXI4-Lite master
//   transactions, one outstanding at a time, with a timeout that forces
//   completion (with error) when a slave stops responding.
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     io_*                     CPU IO bus: strobes, address, byte enables,
//                              write data in; read data and ready pulse out
//     m_aw*/m_w*/m_b*          AXI4-Lite write channels (master side)
//     m_ar*/m_r*               AXI4-Lite read channels (master side)
//     err_pulse                error flag, coincident with io_ready
//     err_count                saturating count of errors and dropped strobes
module io_axil_bridge
    import io_axil_bridge_pkg::*;
#(
    parameter int          TIMEOUT  = 1024,
    parameter logic [31:0] ERR_DATA = DEF_ERR_DATA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_addr_strobe,
    input  logic        io_read_strobe,
    input  logic        io_write_strobe,
    input  logic [31:0] io_addr,
    input  logic [3:0]  io_byte_enable,
    input  logic [31:0] io_write_data,
    output logic [31:0] io_read_data,
    output logic        io_ready,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_awaddr,
    output logic        m_wvalid,
    input  logic        m_wready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic        m_bvalid,
    output logic        m_bready,
    input  logic [1:0]  m_bresp,
    output logic        m_arvalid,
    input  logic        m_arready,
    output logic [31:0] m_araddr,
    input  logic        m_rvalid,
    output logic        m_rready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    output logic        err_pulse,
    output logic [7:0]  err_count
);
    logic [2:0]  r_st;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [3:0]  r_wstrb;
    logic        r_awvalid, r_wvalid, r_ready, r_err;
    logic [7:0]  r_err_cnt;

    logic w_idle, w_issue_wr, w_issue_rd, w_null, w_drop;
    logic w_b_hs, w_r_hs, w_expired, w_to, w_resp_err, w_err;
    logic w_aw_left, w_w_left;
    logic [1:0] w_inc;
    logic w_unused;

    assign w_idle     = (r_st == ST_IDLE);
    assign w_issue_wr = w_idle && io_addr_strobe && io_write_strobe;
    assign w_issue_rd = w_idle && io_addr_strobe && !io_write_strobe && io_read_strobe;
    assign w_null     = w_idle && io_addr_strobe && !io_write_strobe && !io_read_strobe;
    assign w_drop     = !w_idle && io_addr_strobe;

    assign w_b_hs = (r_st == ST_WR_RESP) && m_bvalid;
    assign w_r_hs = (r_st == ST_RD_DATA) && m_rvalid;
    // a response arriving on the expiry edge still completes normally
    assign w_to   = w_expired && !w_b_hs && !w_r_hs;

    assign w_resp_err = (w_b_hs && (m_bresp != RESP_OKAY)) || (w_r_hs && (m_rresp != RESP_OKAY));
    assign w_err      = w_resp_err || w_to;
    // null and dropped strobes are mutually exclusive; an error completion
    // can coincide with a dropped strobe, hence up to +2 per cycle
    assign w_inc      = {1'b0, w_err} + {1'b0, w_null || w_drop};

    assign w_aw_left = r_awvalid && !m_awready;
    assign w_w_left  = r_wvalid && !m_wready;

    axil_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_to (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_issue_wr || w_issue_rd),
        .i_en      (!w_idle),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st      <= ST_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rdata   <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_ready   <= w_b_hs || w_r_hs || w_to;
            r_err     <= w_err;
            r_err_cnt <= sat_add8(r_err_cnt, w_inc);

            if (w_idle && io_addr_strobe) begin
                r_addr  <= {io_addr[31:2], 2'b00};
                r_wdata <= io_write_data;
                r_wstrb <= io_byte_enable;
            end

            if (w_b_hs)
                r_rdata <= '0;
            else if (w_r_hs)
                r_rdata <= m_rdata;
            else if (w_to)
                r_rdata <= (r_st == ST_RD_ADDR || r_st == ST_RD_DATA) ? ERR_DATA : 32'h0;

            case (r_st)
                ST_IDLE: begin
                    if (w_issue_wr) begin
                        r_st      <= ST_WR;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                    end else if (w_issue_rd) begin
                        r_st <= ST_RD_ADDR;
                    end
                end
                ST_WR: begin
                    if (w_to) begin
                        r_st      <= ST_IDLE;
                        r_awvalid <= 1'b0;
                        r_wvalid  <= 1'b0;
                    end else begin
                        r_awvalid <= w_aw_left;
                        r_wvalid  <= w_w_left;
                        if (!w_aw_left && !w_w_left)
                            r_st <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: if (w_b_hs || w_to) r_st <= ST_IDLE;
                ST_RD_ADDR: begin
                    if (w_to)
                        r_st <= ST_IDLE;
                    else if (m_arready)
                        r_st <= ST_RD_DATA;
                end
                ST_RD_DATA: if (w_r_hs || w_to) r_st <= ST_IDLE;
                default:    r_st <= ST_IDLE;
            endcase
        end
    end

    assign io_read_data = r_rdata;
    assign io_ready     = r_ready;
    assign err_pulse    = r_err;
    assign err_count    = r_err_cnt;
    assign m_awvalid    = r_awvalid;
    assign m_awaddr     = r_addr;
    assign m_wvalid     = r_wvalid;
    assign m_wdata      = r_wdata;
    assign m_wstrb      = r_wstrb;
    assign m_bready     = (r_st == ST_WR_RESP);
    assign m_arvalid    = (r_st == ST_RD_ADDR);
    assign m_araddr     = r_addr;
    assign m_rready     = (r_st == ST_RD_DATA);

    assign w_unused = &{1'b0, io_addr[1:0]};

endmodule

// File: tb/tb_io_axil_bridge.sv
module tb_io_axil_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        io_addr_strobe = 1'b0, io_read_strobe = 1'b0, io_write_strobe = 1'b0;
    logic [31:0] io_addr = '0, io_write_data = '0;
    logic [3:0]  io_byte_enable = '0;
    logic [31:0] io_read_data;
    logic        io_ready;
    logic        m_awvalid, m_awready = 1'b0;
    logic [31:0] m_awaddr;
    logic        m_wvalid, m_wready = 1'b0;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_bvalid = 1'b0, m_bready;
    logic [1:0]  m_bresp = 2'b00;
    logic        m_arvalid, m_arready = 1'b0;
    logic [31:0] m_araddr;
    logic        m_rvalid = 1'b0, m_rready;
    logic [31:0] m_rdata = '0;
    logic [1:0]  m_rresp = 2'b00;
    logic        err_pulse;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    io_axil_bridge #(.TIMEOUT(16), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .clk(clk), .rst(rst),
        .io_addr_strobe(io_addr_strobe), .io_read_strobe(io_read_strobe),
        .io_write_strobe(io_write_strobe), .io_addr(io_addr),
        .io_byte_enable(io_byte_enable), .io_write_data(io_write_data),
        .io_read_data(io_read_data), .io_ready(io_ready),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .err_pulse(err_pulse), .err_count(err_count)
    );

    // ---------------- slave model (delays in cycles of valid/ready seen) ----
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic aw_nev = 0, w_nev = 0, ar_nev = 0;
    logic [31:0] s_rdata = '0;
    logic [1:0]  s_rresp = 2'b00, s_bresp = 2'b00;
    int aw_c = 0, w_c = 0, b_c = 0, ar_c = 0, r_c = 0;

    always @(negedge clk) begin
        if (m_awvalid) begin m_awready = !aw_nev && (aw_c >= aw_dly); aw_c++; end
        else begin m_awready = 1'b0; aw_c = 0; end
        if (m_wvalid) begin m_wready = !w_nev && (w_c >= w_dly); w_c++; end
        else begin m_wready = 1'b0; w_c = 0; end
        if (m_arvalid) begin m_arready = !ar_nev && (ar_c >= ar_dly); ar_c++; end
        else begin m_arready = 1'b0; ar_c = 0; end
        if (m_bready) begin m_bvalid = (b_c >= b_dly); b_c++; end
        else begin m_bvalid = 1'b0; b_c = 0; end
        if (m_rready) begin m_rvalid = (r_c >= r_dly); r_c++; end
        else begin m_rvalid = 1'b0; r_c = 0; end
        m_rdata = s_rdata;
        m_rresp = s_rresp;
        m_bresp = s_bresp;
    end

    // ---------------- beat counters and response handshake time -------------
    int cyc = 0, hs_cyc = -10, aw_beats = 0, w_beats = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_awvalid && m_awready) aw_beats <= aw_beats + 1;
        if (m_wvalid && m_wready)   w_beats  <= w_beats + 1;
        if ((m_bvalid && m_bready) || (m_rvalid && m_rready)) hs_cyc <= cyc;
    end

    // ---------------- scoreboard --------------------------------------------
    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        lat;   // check io_ready lands one cycle after response handshake
    } exp_t;
    exp_t sb[$];
    int n_assert = 0, n_fail = 0;
    logic [7:0] exp_ec = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic e, input logic l);
        exp_t x;
        x.data = d; x.err = e; x.lat = l;
        sb.push_back(x);
    endtask

    task automatic set_slave(input int awd, input int wd, input int bd, input int ard, input int rd);
        aw_dly = awd; w_dly = wd; b_dly = bd; ar_dly = ard; r_dly = rd;
        aw_nev = 0; w_nev = 0; ar_nev = 0;
        s_rresp = 2'b00; s_bresp = 2'b00;
    endtask

    // returns at the negedge of cycle 1 (strobe sampled on the edge closing cycle 0)
    task automatic issue(input logic wr, input logic rd, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        io_addr_strobe = 1'b1; io_write_strobe = wr; io_read_strobe = rd;
        io_addr = a; io_write_data = d; io_byte_enable = be;
        @(negedge clk);
        io_addr_strobe = 1'b0; io_write_strobe = 1'b0; io_read_strobe = 1'b0;
    endtask

    task automatic check_completion(input string tag);
        exp_t e;
        chk({tag, "_sb_has_entry"}, {31'b0, sb.size() > 0}, 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk({tag, "_rdata"}, io_read_data, e.data);
        chk({tag, "_err_pulse"}, {31'b0, err_pulse}, {31'b0, e.err});
        chk({tag, "_err_count"}, {24'b0, err_count}, {24'b0, exp_ec});
        if (e.lat) chk({tag, "_latency"}, cyc, hs_cyc + 1);
        @(negedge clk);
        chk({tag, "_one_cycle"}, {31'b0, io_ready}, 32'd0);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!io_ready && n < budget) begin @(negedge clk); n++; end
        chk({tag, "_ready_seen"}, {31'b0, io_ready}, 32'd1);
        if (io_ready) check_completion(tag);
    endtask

    int aw0, w0, pulses;

    initial begin
        // ---- reset state ----
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, io_ready}, 0);
        chk("rst_valids", {28'b0, m_awvalid, m_wvalid, m_arvalid, err_pulse}, 0);
        chk("rst_readies", {30'b0, m_bready, m_rready}, 0);
        chk("rst_rdata", io_read_data, 0);
        chk("rst_awaddr", m_awaddr, 0);
        chk("rst_errcnt", {24'b0, err_count}, 0);
        rst = 1'b0;
        @(negedge clk);

        // ---- write, zero-wait slave ----
        set_slave(0, 0, 0, 0, 0);
        issue(1, 0, 32'h4000_0005, 32'h1234_5678, 4'b0011);
        push(32'h0, 1'b0, 1'b1);
        chk("wr0_valids", {30'b0, m_awvalid, m_wvalid}, 32'd3);
        chk("wr0_awaddr", m_awaddr, 32'h4000_0004);
        chk("wr0_wdata", m_wdata, 32'h1234_5678);
        chk("wr0_wstrb", {28'b0, m_wstrb}, 32'h3);
        wait_done("wr0", 20);

        // ---- write, W accepted 3 cycles before AW, B 5 cycles late ----
        set_slave(3, 0, 5, 0, 0);
        aw0 = aw_beats; w0 = w_beats;
        issue(1, 0, 32'h0000_0100, 32'hA5A5_0001, 4'b1111);
        push(32'h0, 1'b0, 1'b1);
        @(negedge clk);
        chk("wrskew_w_dropped_first", {30'b0, m_awvalid, m_wvalid}, 32'd2);
        wait_done("wrskew", 30);
        repeat (3) @(negedge clk);
        chk("wrskew_aw_beats", aw_beats - aw0, 1);
        chk("wrskew_w_beats", w_beats - w0, 1);

        // ---- read, OKAY after 2 cycles ----
        set_slave(0, 0, 0, 0, 2);
        s_rdata = 32'hCAFE_F00D;
        issue(0, 1, 32'h2000_000E, 32'h0, 4'h0);
        push(32'hCAFE_F00D, 1'b0, 1'b1);
        chk("rd0_arvalid", {31'b0, m_arvalid}, 1);
        chk("rd0_araddr", m_araddr, 32'h2000_000C);
        wait_done("rd0", 20);
        chk("rd0_hold", io_read_data, 32'hCAFE_F00D);

        // ---- read, SLVERR ----
        set_slave(0, 0, 0, 1, 0);
        s_rdata = 32'h1; s_rresp = 2'b10;
        issue(1'b0, 1'b1, 32'h10, 32'h0, 4'h0);
        exp_ec = exp_ec + 1;
        push(32'h1, 1'b1, 1'b1);
        wait_done("rd_slverr", 20);

        // ---- write, DECERR; both strobes set so write wins ----
        set_slave(0, 0, 1, 0, 0);
        s_bresp = 2'b11;
        aw0 = aw_beats;
        issue(1, 1, 32'h30, 32'h5555_AAAA, 4'b0101);
        exp_ec = exp_ec + 1;
        push(32'h0, 1'b1, 1'b1);
        chk("wr_decerr_not_read", {31'b0, m_arvalid}, 0);
        wait_done("wr_decerr", 20);
        chk("wr_decerr_aw_beats", aw_beats - aw0, 1);

        // ---- read timeout: arready never comes ----
        set_slave(0, 0, 0, 0, 0);
        ar_nev = 1'b1;
        issue(0, 1, 32'h50, 32'h0, 4'h0);
        repeat (14) @(negedge clk);
        chk("to_arvalid_c15", {31'b0, m_arvalid}, 1);
        chk("to_noready_c15", {31'b0, io_ready}, 0);
        @(negedge clk);
        chk("to_arvalid_c16", {31'b0, m_arvalid}, 0);
        chk("to_ready_c16", {31'b0, io_ready}, 1);
        exp_ec = exp_ec + 1;
        push(32'hDEAD_BEEF, 1'b1, 1'b0);
        check_completion("to_rd");
        set_slave(0, 0, 0, 0, 0);
        issue(1, 0, 32'h60, 32'h7777_0000, 4'b1000);
        push(32'h0, 1'b0, 1'b1);
        wait_done("wr_after_to", 20);

        // ---- strobe while in RD_DATA is dropped ----
        set_slave(0, 0, 0, 0, 6);
        s_rdata = 32'h0BAD_F00D;
        aw0 = aw_beats;
        issue(0, 1, 32'h70, 32'h0, 4'h0);
        @(negedge clk);
        chk("drop_in_rd_data", {31'b0, m_rready}, 1);
        io_addr_strobe = 1'b1; io_write_strobe = 1'b1; io_addr = 32'h80;
        @(negedge clk);
        io_addr_strobe = 1'b0; io_write_strobe = 1'b0;
        exp_ec = exp_ec + 1;
        chk("drop_errcnt", {24'b0, err_count}, {24'b0, exp_ec});
        push(32'h0BAD_F00D, 1'b0, 1'b1);
        wait_done("drop_rd", 20);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin @(negedge clk); if (io_ready) pulses++; end
        chk("drop_no_extra_ready", pulses, 0);
        chk("drop_no_aw", aw_beats - aw0, 0);

        // ---- strobe with neither read nor write ----
        issue(0, 0, 32'h90, 32'h0, 4'h0);
        exp_ec = exp_ec + 1;
        @(negedge clk);
        chk("null_errcnt", {24'b0, err_count}, {24'b0, exp_ec});
        chk("null_idle", {29'b0, io_ready, m_awvalid, m_arvalid}, 0);

        // ---- reset during WR ----
        set_slave(0, 0, 0, 0, 0);
        aw_nev = 1'b1; w_nev = 1'b1;
        issue(1, 0, 32'hA0, 32'h1111_2222, 4'hF);
        @(negedge clk);
        chk("rstmid_pre_valids", {30'b0, m_awvalid, m_wvalid}, 32'd3);
        rst = 1'b1;
        #1;
        chk("rstmid_valids", {28'b0, m_awvalid, m_wvalid, m_arvalid, m_bready}, 0);
        chk("rstmid_ready_errcnt", {23'b0, io_ready, err_count}, 0);
        exp_ec = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        set_slave(0, 0, 0, 0, 0);
        s_rdata = 32'h0000_ABCD;
        repeat (3) @(negedge clk);
        chk("rstmid_no_completion", {31'b0, io_ready}, 0);
        issue(0, 1, 32'hB0, 32'h0, 4'h0);
        push(32'h0000_ABCD, 1'b0, 1'b1);
        wait_done("rd_after_rst", 20);

        // ---- err_count saturation ----
        for (int i = 0; i < 260; i++) issue(0, 0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk("errcnt_saturate", {24'b0, err_count}, 32'hFF);
        chk("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // safety net against a hung run
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, %0d assertions, %0d failures",
                 n_assert, n_fail);
        $fatal(1, "timeout");
    end

endmodule
